alu_chain_ctrl: RTL and testbench
=================================

ALU_CHAIN_CTRL -- requirements
Module: alu_chain_ctrl

Interface
REQ-001 Parameters: none; ALU width 8, operand width 16, opcode type from package ALU.
REQ-002 clock  in  1  single clock, all state on rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 req_valid / req_ready  in / out  1 / 1  request handshake.
REQ-005 req_op  in  opcode  operation, same encoding as the 8-bit alu.
REQ-006 req_a, req_b  in  16 / 16  operands.
REQ-007 req_carry_in  in  1  carry/rotate input.
REQ-008 alu_op, alu_a, alu_b, alu_carry_in  out  opcode/8/8/1  registered drive to alu.
REQ-009 alu_y, alu_zero, alu_sign, alu_carry_out, alu_overflow  in  8/1/1/1/1  alu outputs, combinational from alu_* drive.
REQ-010 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-011 rsp_y  out  16  result; rsp_zero, rsp_sign, rsp_carry, rsp_overflow, rsp_illegal  out  1 each.

Function
REQ-012 FSM states IDLE, PASS1, PASS2, DONE; req_ready=1 only in IDLE.
REQ-013 Accept on edge with req_valid&&req_ready: latch op/operands/carry, load alu_* with pass-1 byte, go PASS1.
REQ-014 PASS1 edge: capture alu_y and alu_carry_out, load alu_* with pass-2 byte, go PASS2.
REQ-015 PASS2 edge: capture second byte and flags, assert rsp_valid, go DONE; latency accept->rsp_valid = 2 edges.
REQ-016 DONE: rsp_* held stable while rsp_ready=0; edge with rsp_ready=1 drops rsp_valid, go IDLE; no new accept on that edge.
REQ-017 Alu contract: ADD = a+b+cin; SUBTRACT = a-b-cin, carry_out=borrow; SHIFT_* ignore cin; ROTATE_* rotate through carry.
REQ-018 ADD/SUBTRACT: pass1 low byte with req_carry_in, pass2 high byte with pass1 carry_out.
REQ-019 INCREMENT/DECREMENT: issued as ADD/SUBTRACT with b=0x01 low, 0x00 high, cin=0, chained as REQ-018.
REQ-020 BIT_AND/OR/XOR/NOT: low then high, independent; rsp_carry=0, rsp_overflow=0.
REQ-021 SHIFT_LEFT: low SHIFT_LEFT, high ROTATE_LEFT with pass1 carry; ROTATE_LEFT: low with req_carry_in, high chained.
REQ-022 SHIFT_RIGHT: high SHIFT_RIGHT first, low ROTATE_RIGHT chained; ROTATE_RIGHT: high with req_carry_in first, low chained.
REQ-023 Flags: zero = rsp_y==0; sign = rsp_y[15]; carry = pass2 alu_carry_out (0 for logic ops); overflow = high-byte alu_overflow for arithmetic ops, else 0.
REQ-024 Opcode outside defined enum: no alu passes used; rsp_y=0, zero=1, other flags 0, rsp_illegal=1, same 2-edge latency.
REQ-025 req_* changes after accept have no effect on the operation in flight.

Reset
REQ-026 reset_n low: state IDLE immediately, in-flight operation discarded.
REQ-027 Reset values: req_ready=1, rsp_valid=0, rsp_y=0, all rsp flags 0, alu_op=ADD, alu_a=0, alu_b=0, alu_carry_in=0.
REQ-028 First accept possible on first rising edge after reset_n deasserts.

Verification
REQ-029 ADD 0xD0F0+0x9010, cin 0 -> rsp_y 0x6100, carry 1, overflow 1, sign 0, zero 0.
REQ-030 SUBTRACT 0x0050-0x0064, cin 0 -> rsp_y 0xFFEC, carry 1, sign 1, overflow 0.
REQ-031 INCREMENT 0xFFFF -> rsp_y 0x0000, zero 1, carry 1, sign 0, overflow 0.
REQ-032 SHIFT_LEFT 0x8088, cin 1 -> rsp_y 0x0110, carry 1; ROTATE_RIGHT 0x0009, cin 1 -> rsp_y 0x8004, carry 1, sign 1.
REQ-033 rsp_ready=0 for 5 cycles in DONE -> rsp_* stable, req_ready 0; opcode 15 -> rsp_illegal 1, rsp_y 0, zero 1.
REQ-034 reset_n low during PASS1 -> rsp_valid 0, req_ready 1, alu_* reset values without a clock edge; next request completes normally.

Source files
------------

// File: rtl/alu_chain_ctrl.sv
// Runs one 16-bit operation as two chained passes through an external 8-bit ALU.
// Byte order and carry chaining depend on the opcode.
package alu_pkg;
   typedef enum logic [3:0] {
      ADD          = 4'd0,
      SUBTRACT     = 4'd1,
      INCREMENT    = 4'd2,
      DECREMENT    = 4'd3,
      BIT_AND      = 4'd4,
      BIT_OR       = 4'd5,
      BIT_XOR      = 4'd6,
      BIT_NOT      = 4'd7,
      SHIFT_LEFT   = 4'd8,
      SHIFT_RIGHT  = 4'd9,
      ROTATE_LEFT  = 4'd10,
      ROTATE_RIGHT = 4'd11
   } alu_op_t;
endpackage

module alu_chain_ctrl
   import alu_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  alu_op_t     req_op,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   input  logic        req_carry_in,
   output alu_op_t     alu_op,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic        alu_carry_in,
   input  logic [7:0]  alu_y,
   input  logic        alu_zero,
   input  logic        alu_sign,
   input  logic        alu_carry_out,
   input  logic        alu_overflow,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_y,
   output logic        rsp_zero,
   output logic        rsp_sign,
   output logic        rsp_carry,
   output logic        rsp_overflow,
   output logic        rsp_illegal
);

   typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

   state_t      state_reg, state_next;
   alu_op_t     op_reg;
   logic [15:0] a_reg, b_reg;
   logic        legal_reg;
   logic [7:0]  y1_reg;

   alu_op_t     p1_op, p2_op;
   logic [7:0]  p1_a, p1_b, p2_a, p2_b;
   logic        p1_cin, p2_cin, p1_legal;
   logic        is_arith, is_logic, high_first;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = PASS1;
         end
         PASS1: state_next = PASS2;
         PASS2: state_next = DONE;
         DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // First pass comes straight from the request so it can be issued on the accept edge.
   always_comb begin
      p1_op    = ADD;
      p1_a     = req_a[7:0];
      p1_b     = req_b[7:0];
      p1_cin   = 1'b0;
      p1_legal = 1'b1;
      case (req_op)
         ADD, SUBTRACT: begin
            p1_op  = req_op;
            p1_cin = req_carry_in;
         end
         INCREMENT: p1_b = 8'h01;
         DECREMENT: begin
            p1_op = SUBTRACT;
            p1_b  = 8'h01;
         end
         BIT_AND, BIT_OR, BIT_XOR, BIT_NOT, SHIFT_LEFT: p1_op = req_op;
         ROTATE_LEFT: begin
            p1_op  = ROTATE_LEFT;
            p1_cin = req_carry_in;
         end
         SHIFT_RIGHT, ROTATE_RIGHT: begin
            p1_op  = req_op;
            p1_a   = req_a[15:8];
            p1_b   = req_b[15:8];
            p1_cin = (req_op == ROTATE_RIGHT) ? req_carry_in : 1'b0;
         end
         default: p1_legal = 1'b0;
      endcase
   end

   // Second pass chains the live carry_out of the first pass.
   always_comb begin
      p2_op      = ADD;
      p2_a       = a_reg[15:8];
      p2_b       = b_reg[15:8];
      p2_cin     = alu_carry_out;
      is_arith   = 1'b0;
      is_logic   = 1'b0;
      high_first = 1'b0;
      case (op_reg)
         ADD, SUBTRACT: begin
            p2_op    = op_reg;
            is_arith = 1'b1;
         end
         INCREMENT, DECREMENT: begin
            p2_op    = (op_reg == INCREMENT) ? ADD : SUBTRACT;
            p2_b     = 8'h00;
            is_arith = 1'b1;
         end
         BIT_AND, BIT_OR, BIT_XOR, BIT_NOT: begin
            p2_op    = op_reg;
            p2_cin   = 1'b0;
            is_logic = 1'b1;
         end
         SHIFT_LEFT, ROTATE_LEFT: p2_op = ROTATE_LEFT;
         SHIFT_RIGHT, ROTATE_RIGHT: begin
            p2_op      = ROTATE_RIGHT;
            p2_a       = a_reg[7:0];
            p2_b       = b_reg[7:0];
            high_first = 1'b1;
         end
         default: p2_cin = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         op_reg       <= ADD;
         a_reg        <= 16'h0000;
         b_reg        <= 16'h0000;
         legal_reg    <= 1'b0;
         y1_reg       <= 8'h00;
         alu_op       <= ADD;
         alu_a        <= 8'h00;
         alu_b        <= 8'h00;
         alu_carry_in <= 1'b0;
         rsp_y        <= 16'h0000;
         rsp_zero     <= 1'b0;
         rsp_sign     <= 1'b0;
         rsp_carry    <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_illegal  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: if (req_valid) begin
               op_reg    <= req_op;
               a_reg     <= req_a;
               b_reg     <= req_b;
               legal_reg <= p1_legal;
               if (p1_legal) begin
                  alu_op       <= p1_op;
                  alu_a        <= p1_a;
                  alu_b        <= p1_b;
                  alu_carry_in <= p1_cin;
               end
            end
            PASS1: begin
               y1_reg <= alu_y;
               if (legal_reg) begin
                  alu_op       <= p2_op;
                  alu_a        <= p2_a;
                  alu_b        <= p2_b;
                  alu_carry_in <= p2_cin;
               end
            end
            PASS2: begin
               if (legal_reg) begin
                  rsp_y        <= high_first ? {y1_reg, alu_y} : {alu_y, y1_reg};
                  rsp_zero     <= alu_zero && (y1_reg == 8'h00);
                  rsp_sign     <= high_first ? y1_reg[7] : alu_sign;
                  rsp_carry    <= alu_carry_out && !is_logic;
                  rsp_overflow <= alu_overflow && is_arith;
                  rsp_illegal  <= 1'b0;
               end else begin
                  rsp_y        <= 16'h0000;
                  rsp_zero     <= 1'b1;
                  rsp_sign     <= 1'b0;
                  rsp_carry    <= 1'b0;
                  rsp_overflow <= 1'b0;
                  rsp_illegal  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_chain_ctrl.sv
// Directed bench for alu_chain_ctrl with a behavioural 8-bit ALU attached.
module tb_alu_chain_ctrl;
   import alu_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   alu_op_t     req_op = ADD;
   logic [15:0] req_a = 16'h0, req_b = 16'h0;
   logic        req_carry_in = 1'b0;
   alu_op_t     alu_op;
   logic [7:0]  alu_a, alu_b, alu_y;
   logic        alu_carry_in, alu_zero, alu_sign, alu_carry_out, alu_overflow;
   logic        rsp_valid, rsp_ready = 1'b0;
   logic [15:0] rsp_y;
   logic        rsp_zero, rsp_sign, rsp_carry, rsp_overflow, rsp_illegal;

   int errors = 0;
   int checks = 0;
   int lat;

   always #5 clock = ~clock;

   alu_chain_ctrl dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_carry_in(req_carry_in),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
      .alu_y(alu_y), .alu_zero(alu_zero), .alu_sign(alu_sign),
      .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
      .rsp_zero(rsp_zero), .rsp_sign(rsp_sign), .rsp_carry(rsp_carry),
      .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal)
   );

   // Behavioural 8-bit ALU
   logic [8:0] m_t;
   logic [7:0] m_y;
   logic       m_c, m_v;
   always_comb begin
      m_t = 9'd0;
      m_y = 8'd0;
      m_c = 1'b0;
      m_v = 1'b0;
      case (alu_op)
         ADD: begin
            m_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_in};
            m_y = m_t[7:0];
            m_c = m_t[8];
            m_v = (alu_a[7] == alu_b[7]) && (m_y[7] != alu_a[7]);
         end
         SUBTRACT: begin
            m_t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_carry_in};
            m_y = m_t[7:0];
            m_c = m_t[8];
            m_v = (alu_a[7] != alu_b[7]) && (m_y[7] != alu_a[7]);
         end
         BIT_AND:      m_y = alu_a & alu_b;
         BIT_OR:       m_y = alu_a | alu_b;
         BIT_XOR:      m_y = alu_a ^ alu_b;
         BIT_NOT:      m_y = ~alu_a;
         SHIFT_LEFT:   begin m_y = {alu_a[6:0], 1'b0};         m_c = alu_a[7]; end
         SHIFT_RIGHT:  begin m_y = {1'b0, alu_a[7:1]};         m_c = alu_a[0]; end
         ROTATE_LEFT:  begin m_y = {alu_a[6:0], alu_carry_in}; m_c = alu_a[7]; end
         ROTATE_RIGHT: begin m_y = {alu_carry_in, alu_a[7:1]}; m_c = alu_a[0]; end
         default: ;
      endcase
   end
   assign alu_y         = m_y;
   assign alu_carry_out = m_c;
   assign alu_overflow  = m_v;
   assign alu_zero      = (m_y == 8'h00);
   assign alu_sign      = m_y[7];

   // Present a request, let it be accepted, then scramble the request bus.
   task automatic send(input alu_op_t op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin);
      @(negedge clock);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_carry_in = cin;
      @(posedge clock); #1;
      req_valid = 1'b0; req_op = BIT_XOR; req_a = ~a; req_b = ~b; req_carry_in = ~cin;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (rsp_valid !== 1'b1 && n < 10) begin
         @(posedge clock); #1;
         n++;
      end
   endtask

   task automatic release_rsp();
      @(negedge clock); rsp_ready = 1'b1;
      @(posedge clock); #1; rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_y !== 16'h0 ||
          {rsp_zero, rsp_sign, rsp_carry, rsp_overflow, rsp_illegal} !== 5'b0) begin
         errors++;
         $display("FAIL reset_rsp: got ready=%b valid=%b y=%h flags=%b, want 1 0 0000 00000",
                  req_ready, rsp_valid, rsp_y, {rsp_zero, rsp_sign, rsp_carry, rsp_overflow, rsp_illegal});
      end
      checks++;
      if (alu_op !== ADD || alu_a !== 8'h0 || alu_b !== 8'h0 || alu_carry_in !== 1'b0) begin
         errors++;
         $display("FAIL reset_alu: got op=%0d a=%h b=%h cin=%b, want 0 00 00 0",
                  alu_op, alu_a, alu_b, alu_carry_in);
      end
      @(negedge clock); reset_n = 1'b1;
      $display("txn reset released");
   endtask

   task automatic test_add();
      send(ADD, 16'hD0F0, 16'h9010, 1'b0);
      checks++;
      if (alu_op !== ADD || alu_a !== 8'hF0 || alu_b !== 8'h10 || alu_carry_in !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_pass1: got op=%0d a=%h b=%h cin=%b valid=%b, want 0 f0 10 0 0",
                  alu_op, alu_a, alu_b, alu_carry_in, rsp_valid);
      end
      wait_rsp(lat);
      checks++;
      if (lat != 2) begin errors++; $display("FAIL add_latency: got %0d, want 2", lat); end
      checks++;
      if (rsp_y !== 16'h6100 || rsp_carry !== 1'b1 || rsp_overflow !== 1'b1 || rsp_sign !== 1'b0 ||
          rsp_zero !== 1'b0 || rsp_illegal !== 1'b0) begin
         errors++;
         $display("FAIL add_result: got y=%h c=%b v=%b s=%b z=%b il=%b, want 6100 1 1 0 0 0",
                  rsp_y, rsp_carry, rsp_overflow, rsp_sign, rsp_zero, rsp_illegal);
      end
      $display("txn ADD d0f0+9010 -> %h", rsp_y);
      release_rsp();
   endtask

   task automatic test_sub();
      send(SUBTRACT, 16'h0050, 16'h0064, 1'b0);
      wait_rsp(lat);
      checks++;
      if (lat != 2 || rsp_y !== 16'hFFEC || rsp_carry !== 1'b1 || rsp_sign !== 1'b1 ||
          rsp_overflow !== 1'b0 || rsp_zero !== 1'b0) begin
         errors++;
         $display("FAIL sub_result: got lat=%0d y=%h c=%b s=%b v=%b z=%b, want 2 ffec 1 1 0 0",
                  lat, rsp_y, rsp_carry, rsp_sign, rsp_overflow, rsp_zero);
      end
      $display("txn SUB 0050-0064 -> %h", rsp_y);
      release_rsp();
   endtask

   task automatic test_inc();
      send(INCREMENT, 16'hFFFF, 16'h1234, 1'b1);
      wait_rsp(lat);
      checks++;
      if (lat != 2 || rsp_y !== 16'h0000 || rsp_zero !== 1'b1 || rsp_carry !== 1'b1 ||
          rsp_sign !== 1'b0 || rsp_overflow !== 1'b0) begin
         errors++;
         $display("FAIL inc_result: got lat=%0d y=%h z=%b c=%b s=%b v=%b, want 2 0000 1 1 0 0",
                  lat, rsp_y, rsp_zero, rsp_carry, rsp_sign, rsp_overflow);
      end
      $display("txn INC ffff -> %h", rsp_y);
      release_rsp();
   endtask

   task automatic test_logic();
      send(BIT_AND, 16'hF0F0, 16'h0FF0, 1'b1);
      wait_rsp(lat);
      checks++;
      if (lat != 2 || rsp_y !== 16'h00F0 || rsp_carry !== 1'b0 || rsp_overflow !== 1'b0 ||
          rsp_zero !== 1'b0 || rsp_sign !== 1'b0) begin
         errors++;
         $display("FAIL and_result: got lat=%0d y=%h c=%b v=%b z=%b s=%b, want 2 00f0 0 0 0 0",
                  lat, rsp_y, rsp_carry, rsp_overflow, rsp_zero, rsp_sign);
      end
      $display("txn AND f0f0&0ff0 -> %h", rsp_y);
      release_rsp();
   endtask

   task automatic test_shift_left();
      send(SHIFT_LEFT, 16'h8088, 16'h0000, 1'b1);
      wait_rsp(lat);
      checks++;
      if (lat != 2 || rsp_y !== 16'h0110 || rsp_carry !== 1'b1 || rsp_overflow !== 1'b0 || rsp_sign !== 1'b0) begin
         errors++;
         $display("FAIL shl_result: got lat=%0d y=%h c=%b v=%b s=%b, want 2 0110 1 0 0",
                  lat, rsp_y, rsp_carry, rsp_overflow, rsp_sign);
      end
      $display("txn SHL 8088 -> %h", rsp_y);
      release_rsp();
   endtask

   task automatic test_rotate_right();
      send(ROTATE_RIGHT, 16'h0009, 16'h0000, 1'b1);
      checks++;
      if (alu_op !== ROTATE_RIGHT || alu_a !== 8'h00 || alu_carry_in !== 1'b1) begin
         errors++;
         $display("FAIL ror_pass1: got op=%0d a=%h cin=%b, want 11 00 1", alu_op, alu_a, alu_carry_in);
      end
      wait_rsp(lat);
      checks++;
      if (lat != 2 || rsp_y !== 16'h8004 || rsp_carry !== 1'b1 || rsp_sign !== 1'b1 || rsp_zero !== 1'b0) begin
         errors++;
         $display("FAIL ror_result: got lat=%0d y=%h c=%b s=%b z=%b, want 2 8004 1 1 0",
                  lat, rsp_y, rsp_carry, rsp_sign, rsp_zero);
      end
      $display("txn ROR 0009 -> %h", rsp_y);
      release_rsp();
   endtask

   // DECREMENT 0x8000 = 0x7FFF with signed overflow; response held while stalled.
   task automatic test_stall();
      send(DECREMENT, 16'h8000, 16'h5555, 1'b1);
      wait_rsp(lat);
      checks++;
      if (lat != 2 || rsp_y !== 16'h7FFF || rsp_overflow !== 1'b1 || rsp_carry !== 1'b0 || rsp_sign !== 1'b0) begin
         errors++;
         $display("FAIL dec_result: got lat=%0d y=%h v=%b c=%b s=%b, want 2 7fff 1 0 0",
                  lat, rsp_y, rsp_overflow, rsp_carry, rsp_sign);
      end
      @(negedge clock);
      req_valid = 1'b1; req_op = ADD; req_a = 16'h0001; req_b = 16'h0001; req_carry_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         checks++;
         if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_y !== 16'h7FFF || rsp_overflow !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d got valid=%b ready=%b y=%h v=%b, want 1 0 7fff 1",
                     i, rsp_valid, req_ready, rsp_y, rsp_overflow);
         end
      end
      $display("txn DEC 8000 -> %h held 5 cycles", rsp_y);
   endtask

   // Release edge must not accept the pending request; the next edge does.
   task automatic test_back_to_back();
      @(negedge clock); rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_release: got valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept: got ready=%b, want 0", req_ready);
      end
      wait_rsp(lat);
      checks++;
      if (lat != 2 || rsp_y !== 16'h0002 || rsp_carry !== 1'b0) begin
         errors++;
         $display("FAIL b2b_result: got lat=%0d y=%h c=%b, want 2 0002 0", lat, rsp_y, rsp_carry);
      end
      $display("txn ADD 0001+0001 back-to-back -> %h", rsp_y);
      release_rsp();
   endtask

   task automatic test_illegal();
      send(alu_op_t'(4'd15), 16'h1234, 16'h5678, 1'b1);
      wait_rsp(lat);
      checks++;
      if (lat != 2 || rsp_illegal !== 1'b1 || rsp_y !== 16'h0000 || rsp_zero !== 1'b1 ||
          {rsp_sign, rsp_carry, rsp_overflow} !== 3'b000) begin
         errors++;
         $display("FAIL illegal_result: got lat=%0d il=%b y=%h z=%b scv=%b, want 2 1 0000 1 000",
                  lat, rsp_illegal, rsp_y, rsp_zero, {rsp_sign, rsp_carry, rsp_overflow});
      end
      $display("txn op15 -> illegal=%b", rsp_illegal);
      release_rsp();
   endtask

   task automatic test_reset_midflight();
      send(ADD, 16'h1234, 16'h1111, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || alu_op !== ADD || alu_a !== 8'h00 ||
          alu_b !== 8'h00 || alu_carry_in !== 1'b0) begin
         errors++;
         $display("FAIL midreset: got valid=%b ready=%b op=%0d a=%h b=%h cin=%b, want 0 1 0 00 00 0",
                  rsp_valid, req_ready, alu_op, alu_a, alu_b, alu_carry_in);
      end
      @(negedge clock); reset_n = 1'b1;
      send(ADD, 16'h1234, 16'h1111, 1'b1);
      wait_rsp(lat);
      checks++;
      if (lat != 2 || rsp_y !== 16'h2346 || rsp_carry !== 1'b0 || rsp_overflow !== 1'b0 || rsp_illegal !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: got lat=%0d y=%h c=%b v=%b il=%b, want 2 2346 0 0 0",
                  lat, rsp_y, rsp_carry, rsp_overflow, rsp_illegal);
      end
      $display("txn reset mid-flight, then ADD 1234+1111+1 -> %h", rsp_y);
      release_rsp();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_inc();
      test_logic();
      test_shift_left();
      test_rotate_right();
      test_stall();
      test_back_to_back();
      test_illegal();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
